// File: rtl/game_pkg.sv
// Shared game definitions: facing direction, screen geometry, sprite size
// and the bullet FSM state type, plus the bullet boundary test.
package game_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PLAYER_SIZE = 16;

  // True when one more step of `speed` along d would leave the screen.
  // Comparisons use 11 bits so that x + speed never wraps.
  function automatic logic bullet_expires(input dir_t d, input logic [9:0] x,
                                          input logic [9:0] y, input logic [10:0] speed);
    logic res;
    res = 1'b0;
    case (d)
      LEFT:  res = ({1'b0, x} < speed);
      UP:    res = ({1'b0, y} < speed);
      RIGHT: res = (({1'b0, x} + speed) >= 11'(SCREEN_W));
      DOWN:  res = (({1'b0, y} + speed) >= 11'(SCREEN_H));
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// rising-edge detector producing a one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet controller: launch on frame_tick after a fire press, fly along
// the latched direction, expire at the screen edge or on hit. Define
// BULLET_COOLDOWN_EN to insert a COOLDOWN period before the next launch.
module bullet_ctrl
  import game_pkg::*;
#(
  parameter int PLAYER_SIZE     = game_pkg::PLAYER_SIZE,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          fire,
  input  logic          game_reset,
  input  logic          hit,
  input  logic [9:0]    playerX,
  input  logic [9:0]    playerY,
  input  dir_t          dir,
  output logic [9:0]    bulletX,
  output logic [9:0]    bulletY,
  output logic          bullet_active,
  output logic [7:0]    shot_count,
  output bullet_state_t state
);

  bullet_state_t state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic          active_q, active_d;
  logic [7:0]    shots_q, shots_d;
  logic          pend_q, pend_d;
  dir_t          dir_q, dir_d;
  logic          fire_rise;
  logic          expire_now;

`ifdef BULLET_COOLDOWN_EN
  logic [3:0]    cd_q, cd_d;
`endif

  btn_edge u_fire_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (fire),
    .rise  (fire_rise)
  );

  assign expire_now = hit | (frame_tick & bullet_expires(dir_q, bx_q, by_q, 11'(SPEED)));

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    active_d = active_q;
    shots_d  = shots_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
`ifdef BULLET_COOLDOWN_EN
    cd_d     = cd_q;
`endif
    if (game_reset) begin
      state_d  = IDLE;
      bx_d     = '0;
      by_d     = '0;
      active_d = 1'b0;
      pend_d   = 1'b0;
`ifdef BULLET_COOLDOWN_EN
      cd_d     = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick && (pend_q || fire_rise)) begin
            bx_d     = playerX + 10'(PLAYER_SIZE / 2);
            by_d     = playerY + 10'(PLAYER_SIZE / 2);
            dir_d    = dir;
            active_d = 1'b1;
            shots_d  = shots_q + 8'd1;
            pend_d   = 1'b0;
            state_d  = FLYING;
          end else if (fire_rise) begin
            pend_d = 1'b1;
          end
        end
        FLYING: begin
          // Expiry (edge or hit) wins over the move; position is held.
          if (expire_now) begin
            active_d = 1'b0;
`ifdef BULLET_COOLDOWN_EN
            cd_d     = 4'(COOLDOWN_FRAMES);
            state_d  = COOLDOWN;
`else
            state_d  = IDLE;
`endif
          end else if (frame_tick) begin
            case (dir_q)
              UP:      by_d = by_q - 10'(SPEED);
              DOWN:    by_d = by_q + 10'(SPEED);
              LEFT:    bx_d = bx_q - 10'(SPEED);
              default: bx_d = bx_q + 10'(SPEED);
            endcase
          end
        end
        COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
          if (frame_tick) begin
            if (cd_q <= 4'd1) begin
              cd_d    = '0;
              state_d = IDLE;
            end else begin
              cd_d = cd_q - 4'd1;
            end
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      active_q <= 1'b0;
      shots_q  <= '0;
      pend_q   <= 1'b0;
      dir_q    <= UP;
`ifdef BULLET_COOLDOWN_EN
      cd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      active_q <= active_d;
      shots_q  <= shots_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
`ifdef BULLET_COOLDOWN_EN
      cd_q     <= cd_d;
`endif
    end
  end

  assign bulletX       = bx_q;
  assign bulletY       = by_q;
  assign bullet_active = active_q;
  assign shot_count    = shots_q;
  assign state         = state_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_bullet_ctrl;
  import game_pkg::*;

  localparam int T_SPEED = 4;
  localparam int T_HALF  = 8;
  localparam int T_CD    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          fire = 1'b0;
  logic          game_reset = 1'b0;
  logic          hit = 1'b0;
  logic [9:0]    playerX = '0;
  logic [9:0]    playerY = '0;
  dir_t          dir = UP;
  logic [9:0]    bulletX, bulletY;
  logic          bullet_active;
  logic [7:0]    shot_count;
  bullet_state_t state;

  int n_cmp = 0;
  int n_bad = 0;

  bullet_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .game_reset    (game_reset),
    .hit           (hit),
    .playerX       (playerX),
    .playerY       (playerY),
    .dir           (dir),
    .bulletX       (bulletX),
    .bulletY       (bulletY),
    .bullet_active (bullet_active),
    .shot_count    (shot_count),
    .state         (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FLY = 1, M_COOL = 2;
  int m_mode, m_x, m_y, m_act, m_shots, m_pend, m_cd, m_dir;
  bit fire_hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_x = 0; m_y = 0; m_act = 0; m_shots = 0;
      m_pend = 0; m_cd = 0; m_dir = 0;
      fire_hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      bit rise;
      bit oob;
      // A press becomes visible two edges after it is sampled.
      rise = fire_hist[1] && !fire_hist[2];
      fire_hist.push_front(fire);
      void'(fire_hist.pop_back());
      if (game_reset) begin
        m_mode = M_IDLE; m_x = 0; m_y = 0; m_act = 0; m_pend = 0; m_cd = 0;
      end else if (m_mode == M_IDLE) begin
        if (frame_tick && (m_pend || rise)) begin
          m_x = (int'(playerX) + T_HALF) % 1024;
          m_y = (int'(playerY) + T_HALF) % 1024;
          m_dir = int'(dir);
          m_act = 1;
          m_shots = (m_shots + 1) % 256;
          m_pend = 0;
          m_mode = M_FLY;
        end else if (rise) m_pend = 1;
      end else if (m_mode == M_FLY) begin
        oob = (m_dir == 2 && m_x < T_SPEED) || (m_dir == 0 && m_y < T_SPEED) ||
              (m_dir == 3 && m_x + T_SPEED >= 640) || (m_dir == 1 && m_y + T_SPEED >= 480);
        if (hit || (frame_tick && oob)) begin
          m_act = 0;
`ifdef BULLET_COOLDOWN_EN
          m_mode = M_COOL; m_cd = T_CD;
`else
          m_mode = M_IDLE;
`endif
        end else if (frame_tick) begin
          if (m_dir == 0) m_y = (m_y - T_SPEED + 1024) % 1024;
          if (m_dir == 1) m_y = (m_y + T_SPEED) % 1024;
          if (m_dir == 2) m_x = (m_x - T_SPEED + 1024) % 1024;
          if (m_dir == 3) m_x = (m_x + T_SPEED) % 1024;
        end
      end else begin
        if (frame_tick) begin
          m_cd = m_cd - 1;
          if (m_cd == 0) m_mode = M_IDLE;
        end
      end
    end
  end

  function automatic bullet_state_t exp_state(int mode);
    if (mode == M_FLY) return FLYING;
    if (mode == M_COOL) return COOLDOWN;
    return IDLE;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_x", 32'(bulletX), 32'(m_x));
      check("model_y", 32'(bulletY), 32'(m_y));
      check("model_active", 32'(bullet_active), 32'(m_act));
      check("model_shots", 32'(shot_count), 32'(m_shots));
      check("model_state", 32'(state), 32'(exp_state(m_mode)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit ft, input bit gr, input bit h);
    frame_tick = ft; game_reset = gr; hit = h;
    @(negedge clk);
    frame_tick = 1'b0; game_reset = 1'b0; hit = 1'b0;
  endtask

  task automatic press();
    fire = 1'b1;
    repeat (3) step(0, 0, 0);
    fire = 1'b0;
    repeat (3) step(0, 0, 0);
  endtask

  task automatic launch(input int px, input int py, input dir_t d);
    playerX = 10'(px); playerY = 10'(py); dir = d;
    press();
    step(1, 0, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_mode != M_IDLE && n < 40) begin
      step(1, 0, 0);
      n++;
    end
    check("idle_timeout", 32'(n < 40), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_x", 32'(bulletX), 32'd0);
    check("rst_active", 32'(bullet_active), 32'd0);
    check("rst_shots", 32'(shot_count), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    step(0, 0, 0);

    // Launch to the right and fly three ticks.
    launch(100, 200, RIGHT);
    check("d1_x", 32'(bulletX), 32'd108);
    check("d1_y", 32'(bulletY), 32'd208);
    check("d1_active", 32'(bullet_active), 32'd1);
    check("d1_shots", 32'(shot_count), 32'd1);
    repeat (3) step(1, 0, 0);
    check("d1_x3", 32'(bulletX), 32'd120);
    step(0, 0, 1);
    wait_idle();

    // Left edge expiry from x=6.
    launch(1022, 100, LEFT);
    check("d2_x0", 32'(bulletX), 32'd6);
    step(1, 0, 0);
    check("d2_x1", 32'(bulletX), 32'd2);
    step(1, 0, 0);
    check("d2_xheld", 32'(bulletX), 32'd2);
    check("d2_active", 32'(bullet_active), 32'd0);
`ifdef BULLET_COOLDOWN_EN
    check("d2_state", 32'(state), 32'(COOLDOWN));
`else
    check("d2_state", 32'(state), 32'(IDLE));
`endif
    wait_idle();

    // Hit without frame_tick.
    launch(100, 100, UP);
    step(0, 0, 1);
    check("d3_active", 32'(bullet_active), 32'd0);
    check("d3_y", 32'(bulletY), 32'd108);
`ifdef BULLET_COOLDOWN_EN
    repeat (T_CD - 1) step(1, 0, 0);
    check("d3_cool", 32'(state), 32'(COOLDOWN));
    step(1, 0, 0);
    check("d3_idle", 32'(state), 32'(IDLE));
`else
    check("d3_idle", 32'(state), 32'(IDLE));
`endif

    // Second press while flying is discarded.
    launch(600, 100, RIGHT);
    check("d4_x", 32'(bulletX), 32'd608);
    press();
    repeat (7) step(1, 0, 0);
    check("d4_edge", 32'(bulletX), 32'd636);
    step(1, 0, 0);
    check("d4_expired", 32'(bullet_active), 32'd0);
    wait_idle();
    repeat (4) step(1, 0, 0);
    check("d4_norelaunch", 32'(bullet_active), 32'd0);
    check("d4_shots", 32'(shot_count), 32'd4);

    // game_reset together with hit.
    launch(200, 200, DOWN);
    step(1, 0, 0);
    check("d5_y", 32'(bulletY), 32'd212);
    step(0, 1, 1);
    check("d5_state", 32'(state), 32'(IDLE));
    check("d5_x", 32'(bulletX), 32'd0);
    check("d5_y0", 32'(bulletY), 32'd0);
    check("d5_active", 32'(bullet_active), 32'd0);
    check("d5_shots", 32'(shot_count), 32'd5);

    // Asynchronous reset mid-flight.
    launch(292, 50, RIGHT);
    check("d6_x", 32'(bulletX), 32'd300);
    #2 rst_n = 1'b0;
    #1;
    check("d6_x0", 32'(bulletX), 32'd0);
    check("d6_y0", 32'(bulletY), 32'd0);
    check("d6_active", 32'(bullet_active), 32'd0);
    check("d6_shots", 32'(shot_count), 32'd0);
    check("d6_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1, 0, 0);
    check("d6_nolaunch", 32'(bullet_active), 32'd0);

    // 256 launches wrap shot_count.
    for (int i = 0; i < 256; i++) begin
      launch(300, 300, UP);
      if (i == 254) check("d7_255", 32'(shot_count), 32'd255);
      step(0, 0, 1);
      wait_idle();
    end
    check("d7_wrap", 32'(shot_count), 32'd0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) fire = ~fire;
      if ($urandom_range(0, 40) == 0) begin
        playerX = 10'($urandom_range(0, 1023));
        playerY = 10'($urandom_range(0, 1023));
        dir = dir_t'($urandom_range(0, 3));
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
